// File: rtl/pm_clk_gate_ctrl_if.sv
// Signal bundle between the clock-gate controller and its CSR, wake-source and Q-channel peers.
// The master side is the controller; the slave side is everything around it.
interface pm_clk_gate_ctrl_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned GC_W = 16;

    logic               scan_mode;
    logic [NUM_REQ-1:0] wake_req;
    logic               dom_busy;
    logic               force_on;
    logic               hyst_wr;
    logic [CNT_W-1:0]   hyst_val;
    logic               qaccept_n;
    logic               qdeny;
    logic               qreq_n;
    logic               clk_en;
    logic               clk_active;
    logic [GC_W-1:0]    gate_cnt;

    modport master (
        input  scan_mode, wake_req, dom_busy, force_on, hyst_wr, hyst_val, qaccept_n, qdeny,
        output qreq_n, clk_en, clk_active, gate_cnt
    );

    modport slave (
        output scan_mode, wake_req, dom_busy, force_on, hyst_wr, hyst_val, qaccept_n, qdeny,
        input  qreq_n, clk_en, clk_active, gate_cnt
    );
endinterface

// File: rtl/pm_clk_gate_ctrl.sv
// Idle-detect clock-gating controller: hysteresis timer plus Q-channel handshake
// driving the enable of one gated sub-domain's clock header.
module pm_clk_gate_ctrl #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DEFAULT_HYST = 16
) (
    input  logic                 clk,
    input  logic                 rst_l,
    pm_clk_gate_ctrl_if.master   ctrl_if
);
    localparam int unsigned GC_W = 16;

    typedef enum logic [2:0] {
        S_RUN, S_IDLE_WAIT, S_Q_REQ, S_GATED, S_EXIT, S_DENIED
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hyst_q, hyst_d;
    logic [GC_W-1:0]    gate_cnt_q, gate_cnt_d;
    logic               qreq_n_q, qreq_n_d;
    logic               clk_active_q, clk_active_d;
    logic [NUM_REQ-1:0] wake_req;
    logic               wake;
    logic               active;

    assign wake_req = ctrl_if.wake_req;

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        wake         = (|wake_req) | ctrl_if.force_on;
        active       = wake | ctrl_if.dom_busy;
        state_d      = state_q;
        cnt_d        = cnt_q;
        gate_cnt_d   = gate_cnt_q;
        hyst_d       = ctrl_if.hyst_wr ? ctrl_if.hyst_val : hyst_q;
        qreq_n_d     = 1'b1;
        clk_active_d = 1'b1;

        case (state_q)
            S_RUN: begin
                if (!active) begin
                    if (hyst_q == '0) begin
                        state_d = S_Q_REQ;
                    end else begin
                        state_d = S_IDLE_WAIT;
                        cnt_d   = hyst_q;
                    end
                end
            end
            S_IDLE_WAIT: begin
                if (active) begin
                    state_d = S_RUN;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_Q_REQ;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // A wake here is held off until the domain has answered.
            S_Q_REQ: begin
                if (!ctrl_if.qaccept_n) begin
                    state_d = S_GATED;
                    if (gate_cnt_q != '1) begin
                        gate_cnt_d = gate_cnt_q + GC_W'(1);
                    end
                end else if (ctrl_if.qdeny) begin
                    state_d = S_DENIED;
                end
            end
            S_GATED: begin
                if (wake) begin
                    state_d = S_EXIT;
                end
            end
            S_EXIT: begin
                if (ctrl_if.qaccept_n) begin
                    state_d = S_RUN;
                end
            end
            S_DENIED: begin
                if (!ctrl_if.qdeny) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        qreq_n_d     = !((state_d == S_Q_REQ) || (state_d == S_GATED));
        clk_active_d = (state_d != S_GATED);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= S_RUN;
            cnt_q        <= '0;
            hyst_q       <= CNT_W'(DEFAULT_HYST);
            gate_cnt_q   <= '0;
            qreq_n_q     <= 1'b1;
            clk_active_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hyst_q       <= hyst_d;
            gate_cnt_q   <= gate_cnt_d;
            qreq_n_q     <= qreq_n_d;
            clk_active_q <= clk_active_d;
        end
    end

    // Flop outputs keep the header enable glitch-free; scan only overrides the enable.
    assign ctrl_if.qreq_n     = qreq_n_q;
    assign ctrl_if.clk_active = clk_active_q;
    assign ctrl_if.clk_en     = clk_active_q | ctrl_if.scan_mode;
    assign ctrl_if.gate_cnt   = gate_cnt_q;
endmodule

// File: tb/tb_pm_clk_gate_ctrl.sv
// Self-checking bench for pm_clk_gate_ctrl: per-cycle scoreboard against a behavioural
// model plus directed latency/handshake checks.
module tb_pm_clk_gate_ctrl;
    localparam int M_RUN = 0, M_IW = 1, M_QREQ = 2, M_GATED = 3, M_EXIT = 4, M_DEN = 5;

    typedef struct {
        logic        qreq_n;
        logic        clk_en;
        logic        clk_active;
        logic [15:0] gate_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_l;
    int   n_checks = 0;
    int   n_errs   = 0;
    exp_t exp_q[$];

    int          m_st;
    int          m_cnt;
    int          m_hyst;
    logic [15:0] m_gc;

    pm_clk_gate_ctrl_if #(.NUM_REQ(4), .CNT_W(8)) bus ();

    pm_clk_gate_ctrl #(.NUM_REQ(4), .CNT_W(8), .DEFAULT_HYST(16)) dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .ctrl_if (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_RUN; m_cnt = 0; m_hyst = 16; m_gc = 16'h0;
    endtask

    // Reference behaviour for one clock edge, using the inputs currently driven.
    task automatic model_step();
        logic wk, act;
        int   nh;
        wk  = (|bus.wake_req) || bus.force_on;
        act = wk || bus.dom_busy;
        nh  = bus.hyst_wr ? int'(bus.hyst_val) : m_hyst;
        if (m_st == M_RUN) begin
            if (!act) begin
                if (m_hyst == 0) m_st = M_QREQ;
                else begin m_st = M_IW; m_cnt = m_hyst; end
            end
        end else if (m_st == M_IW) begin
            if (act) m_st = M_RUN;
            else if (m_cnt == 1) m_st = M_QREQ;
            else m_cnt = m_cnt - 1;
        end else if (m_st == M_QREQ) begin
            if (!bus.qaccept_n) begin
                m_st = M_GATED;
                if (m_gc != 16'hFFFF) m_gc = m_gc + 16'd1;
            end else if (bus.qdeny) m_st = M_DEN;
        end else if (m_st == M_GATED) begin
            if (wk) m_st = M_EXIT;
        end else if (m_st == M_EXIT) begin
            if (bus.qaccept_n) m_st = M_RUN;
        end else begin
            if (!bus.qdeny) m_st = M_RUN;
        end
        m_hyst = nh;
    endtask

    // Push the expectation for the coming edge, clock once, then pop and compare.
    task automatic cycle();
        exp_t e;
        model_step();
        e.qreq_n     = !(m_st == M_QREQ || m_st == M_GATED);
        e.clk_active = (m_st != M_GATED);
        e.clk_en     = (m_st != M_GATED) || bus.scan_mode;
        e.gate_cnt   = m_gc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("sb_qreq_n",     32'(bus.qreq_n),     32'(e.qreq_n));
        check_eq("sb_clk_en",     32'(bus.clk_en),     32'(e.clk_en));
        check_eq("sb_clk_active", 32'(bus.clk_active), 32'(e.clk_active));
        check_eq("sb_gate_cnt",   32'(bus.gate_cnt),   32'(e.gate_cnt));
    endtask

    // Count edges until qreq_n goes low; a bound of 40 keeps the bench from hanging.
    task automatic wait_qreq(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n++;
            if (bus.qreq_n == 1'b0) break;
        end
    endtask

    initial begin
        int n;
        rst_l         = 1'b0;
        bus.scan_mode = 1'b0;
        bus.wake_req  = '0;
        bus.dom_busy  = 1'b1;
        bus.force_on  = 1'b0;
        bus.hyst_wr   = 1'b0;
        bus.hyst_val  = '0;
        bus.qaccept_n = 1'b1;
        bus.qdeny     = 1'b0;
        model_reset();
        #12;
        check_eq("rst_clk_en",     32'(bus.clk_en),     32'd1);
        check_eq("rst_clk_active", 32'(bus.clk_active), 32'd1);
        check_eq("rst_qreq_n",     32'(bus.qreq_n),     32'd1);
        check_eq("rst_gate_cnt",   32'(bus.gate_cnt),   32'd0);
        rst_l = 1'b1;

        // Default hysteresis of 16, then accept.
        cycle(); cycle();
        bus.dom_busy = 1'b0;
        cycle();
        wait_qreq(n);
        check_eq("hyst16_latency", 32'(n), 32'd16);
        bus.qaccept_n = 1'b0;
        cycle();
        check_eq("gate_clk_en", 32'(bus.clk_en), 32'd0);
        check_eq("gate_cnt1",   32'(bus.gate_cnt), 32'd1);

        // One-cycle wake pulse; EXIT holds while qaccept_n stays low.
        bus.wake_req[2] = 1'b1;
        cycle();
        bus.wake_req = '0;
        check_eq("wake_clk_en", 32'(bus.clk_en), 32'd1);
        check_eq("wake_qreq_n", 32'(bus.qreq_n), 32'd1);
        cycle(); cycle(); cycle();
        bus.qaccept_n = 1'b1;
        bus.dom_busy  = 1'b1;
        cycle();
        check_eq("exit_run_active", 32'(bus.clk_active), 32'd1);

        // Hysteresis 5, interrupted by activity on idle cycle 3.
        bus.hyst_wr = 1'b1; bus.hyst_val = 8'd5;
        cycle();
        bus.hyst_wr = 1'b0; bus.dom_busy = 1'b0;
        cycle(); cycle(); cycle();
        bus.dom_busy = 1'b1;
        cycle();
        check_eq("busy_no_qreq", 32'(bus.qreq_n), 32'd1);
        bus.dom_busy = 1'b0;
        cycle();
        wait_qreq(n);
        check_eq("hyst5_latency", 32'(n), 32'd5);

        // Deny, then simultaneous accept and deny.
        bus.qdeny = 1'b1;
        cycle();
        check_eq("deny_qreq_n",   32'(bus.qreq_n),   32'd1);
        check_eq("deny_gate_cnt", 32'(bus.gate_cnt), 32'd1);
        cycle();
        bus.qdeny = 1'b0;
        cycle();
        cycle();
        wait_qreq(n);
        check_eq("deny_rerun_latency", 32'(n), 32'd5);
        bus.qaccept_n = 1'b0; bus.qdeny = 1'b1;
        cycle();
        bus.qdeny = 1'b0;
        check_eq("both_gated",   32'(bus.clk_active), 32'd0);
        check_eq("both_gatecnt", 32'(bus.gate_cnt),   32'd2);

        // force_on wakes; zero hysteresis goes straight to the request.
        bus.force_on = 1'b1;
        cycle();
        bus.force_on = 1'b0;
        check_eq("force_wake", 32'(bus.clk_en), 32'd1);
        bus.qaccept_n = 1'b1; bus.dom_busy = 1'b1;
        cycle();
        bus.hyst_wr = 1'b1; bus.hyst_val = 8'd0;
        cycle();
        bus.hyst_wr = 1'b0; bus.dom_busy = 1'b0;
        cycle();
        check_eq("hyst0_qreq", 32'(bus.qreq_n), 32'd0);
        bus.qaccept_n = 1'b0;
        cycle();
        bus.scan_mode = 1'b1;
        cycle();
        check_eq("scan_clk_en",     32'(bus.clk_en),     32'd1);
        check_eq("scan_clk_active", 32'(bus.clk_active), 32'd0);
        bus.scan_mode = 1'b0;

        // Saturation: preload near the top, then gate twice.
        force dut.gate_cnt_q = 16'hFFFE;
        #1;
        release dut.gate_cnt_q;
        m_gc = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            bus.force_on = 1'b1;
            cycle();
            bus.force_on = 1'b0; bus.qaccept_n = 1'b1;
            cycle();
            cycle();
            bus.qaccept_n = 1'b0;
            cycle();
            check_eq("sat_gate_cnt", 32'(bus.gate_cnt), 32'hFFFF);
        end

        // Reset while in Q_REQ.
        bus.force_on = 1'b1;
        cycle();
        bus.force_on = 1'b0; bus.qaccept_n = 1'b1;
        cycle();
        cycle();
        check_eq("pre_rst_qreq", 32'(bus.qreq_n), 32'd0);
        rst_l = 1'b0;
        #1;
        check_eq("arst_clk_en",   32'(bus.clk_en),   32'd1);
        check_eq("arst_qreq_n",   32'(bus.qreq_n),   32'd1);
        check_eq("arst_gate_cnt", 32'(bus.gate_cnt), 32'd0);
        model_reset();
        #1;
        rst_l = 1'b1;
        bus.dom_busy = 1'b1;
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
